// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential vedic multiplier.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DIGIT_W = 2;
    localparam int unsigned PP_W    = 4;

    // Number of 2-bit digits in an operand of width op_w.
    function automatic int unsigned digits(input int unsigned op_w);
        return op_w / DIGIT_W;
    endfunction

endpackage

// File: rtl/vedic_pp_2x2.sv
// 2x2 vedic partial-product core: vertical and crosswise terms of two 2-bit digits.
module vedic_pp_2x2
    import vedic_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic [PP_W-1:0]    p
);

    logic cross_carry_c;

    // Crosswise carry is set only when both cross terms are 1 (a1&a0&b1&b0).
    always_comb begin
        cross_carry_c = a[1] & b[0] & a[0] & b[1];
        p[0]          = a[0] & b[0];
        p[1]          = (a[1] & b[0]) ^ (a[0] & b[1]);
        p[2]          = (a[1] & b[1]) ^ cross_carry_c;
        p[3]          = a[1] & b[1] & cross_carry_c;
    end

endmodule

// File: rtl/vedic_seq_mult.sv
// Sequential NxN vedic multiplier: one 2x2 digit product per cycle, shifted and
// accumulated into a 2*OP_W result, valid/ready on both sides.
// Optional feature macro: VEDIC_ZERO_SKIP_EN (zero operand bypasses CALC).
module vedic_seq_mult
    import vedic_pkg::*;
#(
    parameter int unsigned OP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   mul_1,
    input  logic [OP_W-1:0]   mul_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*OP_W-1:0] product,
    output logic              busy
);

    localparam int unsigned DIGITS = digits(OP_W);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PROD_W = 2 * OP_W;

`ifdef VEDIC_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    state_t             state_q, state_next_c;
    logic [OP_W-1:0]    a_q, b_q;
    logic [PROD_W-1:0]  acc_q;
    logic [IDX_W-1:0]   i_q, j_q;
    logic [DIGIT_W-1:0] a_dig_c, b_dig_c;
    logic [PP_W-1:0]    pp_c;
    logic [31:0]        shamt_c;
    logic [PROD_W-1:0]  acc_next_c;
    logic               last_c;
    logic               zero_op_c;

    vedic_pp_2x2 u_pp (
        .a (a_dig_c),
        .b (b_dig_c),
        .p (pp_c)
    );

    // Digit selection, weighting and accumulation for the current (i, j) pair.
    always_comb begin
        a_dig_c    = a_q[DIGIT_W*i_q +: DIGIT_W];
        b_dig_c    = b_q[DIGIT_W*j_q +: DIGIT_W];
        shamt_c    = DIGIT_W * (32'(i_q) + 32'(j_q));
        acc_next_c = acc_q + (PROD_W'(pp_c) << shamt_c);
        last_c     = (i_q == IDX_W'(DIGITS - 1)) && (j_q == IDX_W'(DIGITS - 1));
        zero_op_c  = ZERO_SKIP && ((mul_1 == '0) || (mul_2 == '0));
    end

    // Next-state logic.
    always_comb begin
        state_next_c = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_next_c = zero_op_c ? DONE : CALC;
            CALC: if (last_c) state_next_c = DONE;
            DONE: if (out_ready) state_next_c = IDLE;
            default: state_next_c = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_next_c;
    end

    // Operand capture, digit walk, accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= mul_1;
                        b_q   <= mul_2;
                        acc_q <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
                        if (zero_op_c) product <= '0;
                    end
                end
                CALC: begin
                    acc_q <= acc_next_c;
                    if (j_q == IDX_W'(DIGITS - 1)) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                    if (last_c) product <= acc_next_c;
                end
                default: ;
            endcase
            out_valid <= (state_next_c == DONE);
            busy      <= (state_next_c != IDLE);
        end
    end

    // Accept only from IDLE; depends on state alone.
    assign in_ready = (state_q == IDLE);

endmodule

// File: tb/tb_vedic_seq_mult.sv
// Self-checking bench for vedic_seq_mult at OP_W=4 and OP_W=8 against a plain a*b model.
// Latencies are counted with the accept edge as cycle 1.
module tb_vedic_seq_mult;

    logic        clk;
    logic        reset;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0]  m1_4, m2_4;
    logic [7:0]  product4;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  m1_8, m2_8;
    logic [15:0] product8;

    int n_cmp;
    int n_err;

    vedic_seq_mult #(.OP_W(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .mul_1     (m1_4),
        .mul_2     (m2_4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .product   (product4),
        .busy      (busy4)
    );

    vedic_seq_mult #(.OP_W(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .mul_1     (m1_8),
        .mul_2     (m2_8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8),
        .busy      (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic ir(input bit w8);
        return w8 ? in_ready8 : in_ready4;
    endfunction

    function automatic logic ov(input bit w8);
        return w8 ? out_valid8 : out_valid4;
    endfunction

    function automatic logic bz(input bit w8);
        return w8 ? busy8 : busy4;
    endfunction

    function automatic logic [15:0] pr(input bit w8);
        return w8 ? product8 : {8'h00, product4};
    endfunction

    // Reference latency: accept edge plus one cycle per digit pair, or just the accept edge on zero skip.
    function automatic int exp_lat(input bit w8, input logic [7:0] a, input logic [7:0] b);
        int d;
        d = w8 ? 4 : 2;
`ifdef VEDIC_ZERO_SKIP_EN
        if (a == 8'h00 || b == 8'h00) return 1;
`else
        if (a == 8'h00 && b == 8'h00 && d == 0) return 0;
`endif
        return d * d + 1;
    endfunction

    task automatic drv(input bit w8, input logic v, input logic [7:0] a, input logic [7:0] b, input logic ordy);
        if (w8) begin
            in_valid8 = v; m1_8 = a; m2_8 = b; out_ready8 = ordy;
        end else begin
            in_valid4 = v; m1_4 = a[3:0]; m2_4 = b[3:0]; out_ready4 = ordy;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: wait ready, present operands, wait result, optional back-pressure, handshake.
    task automatic op(input bit w8, input logic [7:0] a, input logic [7:0] b, input int hold,
                      output logic [15:0] res, output int lat, output int low);
        int t;
        logic [15:0] exp_p;
        t = 0;
        while (!ir(w8) && t < 200) begin step(); t++; end
        chk("in_ready_before_accept", 32'(ir(w8)), 32'd1);
        drv(w8, 1'b1, a, b, hold == 0);
        step();
        drv(w8, 1'b0, a, b, hold == 0);
        lat = 1;
        low = ir(w8) ? 0 : 1;
        while (!ov(w8) && lat < 200) begin
            step();
            lat++;
            if (!ir(w8)) low++;
        end
        exp_p = 16'(a) * 16'(b);
        res = pr(w8);
        chk(w8 ? "latency8" : "latency4", 32'(lat), 32'(exp_lat(w8, a, b)));
        chk(w8 ? "product8" : "product4", 32'(res), 32'(exp_p));
        chk("busy_in_done", 32'(bz(w8)), 32'd1);
        for (int k = 0; k < hold; k++) begin
            step();
            chk("held_product", 32'(pr(w8)), 32'(exp_p));
            chk("held_out_valid", 32'(ov(w8)), 32'd1);
        end
        drv(w8, 1'b0, a, b, 1'b1);
        step();
        drv(w8, 1'b0, a, b, 1'b0);
        chk("out_valid_fall", 32'(ov(w8)), 32'd0);
        chk("in_ready_return", 32'(ir(w8)), 32'd1);
        chk("busy_idle", 32'(bz(w8)), 32'd0);
    endtask

    initial begin
        logic [15:0] res;
        logic [7:0]  ra, rb;
        int          lat, low, t;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drv(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        #23;

        // Reset values.
        chk("rst_product", 32'(product4), 32'd0);
        chk("rst_out_valid", 32'(out_valid4), 32'd0);
        chk("rst_busy", 32'(busy4), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready4), 32'd1);

        // 3x3 with out_ready already high.
        op(1'b0, 8'd3, 8'd3, 0, res, lat, low);

        // 15x15 and the in_ready low window.
        op(1'b0, 8'd15, 8'd15, 0, res, lat, low);
        chk("in_ready_low_cycles", 32'(low), 32'd5);

        // 13x11 held under back-pressure for 10 cycles.
        op(1'b0, 8'd13, 8'd11, 10, res, lat, low);

        // 7x9 aborted by reset in the second CALC cycle.
        drv(1'b0, 1'b1, 8'd7, 8'd9, 1'b1);
        step();
        drv(1'b0, 1'b0, 8'd7, 8'd9, 1'b1);
        step();
        reset = 1'b0;
        #2;
        chk("abort_out_valid", 32'(out_valid4), 32'd0);
        chk("abort_product", 32'(product4), 32'd0);
        chk("abort_busy", 32'(busy4), 32'd0);
        chk("abort_in_ready", 32'(in_ready4), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        drv(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        step();
        op(1'b0, 8'd2, 8'd5, 0, res, lat, low);

        // Zero operand.
        op(1'b0, 8'd0, 8'd12, 0, res, lat, low);

        // Back-to-back: in_valid stays high with the next pair during CALC/DONE.
        drv(1'b0, 1'b1, 8'd6, 8'd7, 1'b1);
        step();
        drv(1'b0, 1'b1, 8'd10, 8'd10, 1'b1);
        t = 1;
        while (!out_valid4 && t < 200) begin step(); t++; end
        chk("b2b_first", 32'(product4), 32'd42);
        chk("b2b_first_lat", 32'(t), 32'(exp_lat(1'b0, 8'd6, 8'd7)));
        step();
        chk("b2b_gap_out_valid", 32'(out_valid4), 32'd0);
        chk("b2b_gap_in_ready", 32'(in_ready4), 32'd1);
        step();
        drv(1'b0, 1'b0, 8'd10, 8'd10, 1'b1);
        t = 1;
        while (!out_valid4 && t < 200) begin step(); t++; end
        chk("b2b_second", 32'(product4), 32'd100);
        step();
        drv(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        chk("b2b_done", 32'(out_valid4), 32'd0);

        // Random operands at OP_W=4 with random back-pressure.
        for (int n = 0; n < 16; n++) begin
            ra = 8'($urandom_range(0, 15));
            rb = 8'($urandom_range(0, 15));
            op(1'b0, ra, rb, int'($urandom_range(0, 2)), res, lat, low);
        end

        // OP_W=8 corners and random operands.
        op(1'b1, 8'd255, 8'd255, 0, res, lat, low);
        op(1'b1, 8'd0, 8'd119, 1, res, lat, low);
        op(1'b1, 8'd1, 8'd255, 0, res, lat, low);
        for (int n = 0; n < 16; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            op(1'b1, ra, rb, int'($urandom_range(0, 2)), res, lat, low);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
